// File: rtl/hd63701_sci.sv
// HD63701-style SCI: 8N1 async transmitter/receiver with an
// RMCR-selected bit rate and configurable-depth RX/TX FIFOs.
module hd63701_sci_fifo_q #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push_ok, pop_ok;

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rp];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= inc(wp);
            if (pop_ok) rp <= inc(rp);
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end
endmodule

module hd63701_sci_fifo #(
    parameter logic [15:0] BASE_ADDR  = 16'h0010,
    parameter int          DEPTH      = 4,
    parameter int          CLKS_PER_E = 2
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic        mcu_rd,
    input  logic [7:0]  mcu_do,
    input  logic        rx,
    output logic        txd,
    output logic        te,
    output logic        irq,
    output logic        en_sci,
    output logic [7:0]  iod
);
    localparam int CW = $clog2(CLKS_PER_E * 4096) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} sci_st_t;

    logic [15:0] off;
    logic        sel_rmcr, sel_trcsr, sel_rdr, sel_tdr;
    logic        wr_rmcr, wr_trcsr, wr_tdr, rd_trcsr, rd_rdr;
    logic [7:0]  rmcr, rdr_hold, tdr_last;
    logic [4:1]  ctrl;
    logic        rie, re, tie;
    logic        orfe, clr_arm, orfe_set;
    logic        rdrf, tdre;

    logic [7:0]  rx_head, tx_head;
    logic        rx_empty, rx_full, tx_empty, tx_full;

    function automatic logic [CW-1:0] period(input logic [1:0] r);
        logic [CW-1:0] p;
        unique case (r)
            2'd0:    p = CW'(CLKS_PER_E * 16);
            2'd1:    p = CW'(CLKS_PER_E * 128);
            2'd2:    p = CW'(CLKS_PER_E * 1024);
            default: p = CW'(CLKS_PER_E * 4096);
        endcase
        return p;
    endfunction

    assign off       = mcu_ad - BASE_ADDR;
    assign en_sci    = off < 16'd4;
    assign sel_rmcr  = en_sci && off[1:0] == 2'd0;
    assign sel_trcsr = en_sci && off[1:0] == 2'd1;
    assign sel_rdr   = en_sci && off[1:0] == 2'd2;
    assign sel_tdr   = en_sci && off[1:0] == 2'd3;
    assign wr_rmcr   = mcu_wr && sel_rmcr;
    assign wr_trcsr  = mcu_wr && sel_trcsr;
    assign wr_tdr    = mcu_wr && sel_tdr;
    assign rd_trcsr  = mcu_rd && sel_trcsr;
    assign rd_rdr    = mcu_rd && sel_rdr;

    assign {rie, re, tie, te} = ctrl;
    assign rdrf = !rx_empty;
    assign tdre = !tx_full;

    // ---------------- receiver ----------------
    sci_st_t       rx_st, rx_nxt;
    logic          rx_s1, rx_s2, rx_d, rx_fall;
    logic [CW-1:0] rx_cnt, rx_per, rx_half, rx_last;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_clr, rx_shift, rx_push, rx_ferr;

    assign rx_fall = rx_d && !rx_s2;
    assign rx_half = (rx_per >> 1) - CW'(1);
    assign rx_last = rx_per - CW'(1);

    always_comb begin
        rx_nxt   = rx_st;
        rx_clr   = 1'b0;
        rx_shift = 1'b0;
        rx_push  = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st)
            S_IDLE: if (re && rx_fall) begin
                rx_nxt = S_START;
                rx_clr = 1'b1;
            end
            S_START: if (!re) rx_nxt = S_IDLE;
            else if (rx_cnt == rx_half) begin
                rx_clr = 1'b1;
                rx_nxt = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (!re) rx_nxt = S_IDLE;
            else if (rx_cnt == rx_last) begin
                rx_clr   = 1'b1;
                rx_shift = 1'b1;
                if (rx_bit == 3'd7) rx_nxt = S_STOP;
            end
            S_STOP: if (!re) rx_nxt = S_IDLE;
            else if (rx_cnt == rx_last) begin
                rx_nxt  = S_IDLE;
                rx_push = rx_s2;
                rx_ferr = !rx_s2;
            end
            default: rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mcu_clx2) begin
        if (mcu_rst) begin
            {rx_s1, rx_s2, rx_d} <= 3'b111;
            rx_st  <= S_IDLE;
            rx_cnt <= '0;
            rx_per <= period(2'b00);
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            rx_s1  <= rx;
            rx_s2  <= rx_s1;
            rx_d   <= rx_s2;
            rx_st  <= rx_nxt;
            rx_cnt <= rx_clr ? '0 : rx_cnt + CW'(1);
            if (rx_clr) rx_per <= period(rmcr[1:0]);
            if (rx_st != S_DATA) rx_bit <= '0;
            else if (rx_shift) rx_bit <= rx_bit + 3'd1;
            if (rx_shift) rx_sh <= {rx_s2, rx_sh[7:1]};
        end
    end

    hd63701_sci_fifo_q #(.DEPTH(DEPTH)) u_rxq (
        .clk(mcu_clx2), .rst(mcu_rst),
        .push(rx_push), .din(rx_sh), .pop(rd_rdr),
        .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    // A same-cycle pop makes room, so only a stalled full FIFO overruns
    assign orfe_set = rx_ferr || (rx_push && rx_full && !(rd_rdr && rdrf));

    // ---------------- transmitter ----------------
    sci_st_t       tx_st, tx_nxt;
    logic [CW-1:0] tx_cnt, tx_per;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_tick, tx_pop, tx_shift, txd_nxt;

    assign tx_tick = tx_cnt == tx_per - CW'(1);

    always_comb begin
        tx_nxt   = tx_st;
        tx_pop   = 1'b0;
        tx_shift = 1'b0;
        txd_nxt  = txd;
        if (tx_tick) begin
            unique case (tx_st)
                S_IDLE: if (te && !tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_nxt  = S_START;
                    txd_nxt = 1'b0;
                end
                S_START: begin
                    tx_nxt   = S_DATA;
                    tx_shift = 1'b1;
                    txd_nxt  = tx_sh[0];
                end
                S_DATA: if (tx_bit == 3'd7) begin
                    tx_nxt  = S_STOP;
                    txd_nxt = 1'b1;
                end else begin
                    tx_shift = 1'b1;
                    txd_nxt  = tx_sh[0];
                end
                S_STOP: if (te && !tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_nxt  = S_START;
                    txd_nxt = 1'b0;
                end else begin
                    tx_nxt  = S_IDLE;
                    txd_nxt = 1'b1;
                end
                default: begin
                    tx_nxt  = S_IDLE;
                    txd_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge mcu_clx2) begin
        if (mcu_rst) begin
            tx_st  <= S_IDLE;
            txd    <= 1'b1;
            tx_cnt <= '0;
            tx_per <= period(2'b00);
            tx_bit <= '0;
            tx_sh  <= '0;
        end else begin
            tx_st <= tx_nxt;
            txd   <= txd_nxt;
            if (tx_tick) begin
                tx_cnt <= '0;
                tx_per <= period(rmcr[1:0]);
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
            if (tx_pop) tx_sh <= tx_head;
            else if (tx_shift) tx_sh <= {1'b0, tx_sh[7:1]};
            if (tx_st == S_START) tx_bit <= '0;
            else if (tx_shift) tx_bit <= tx_bit + 3'd1;
        end
    end

    hd63701_sci_fifo_q #(.DEPTH(DEPTH)) u_txq (
        .clk(mcu_clx2), .rst(mcu_rst),
        .push(wr_tdr), .din(mcu_do), .pop(tx_pop),
        .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    // ---------------- registers ----------------
    always_ff @(posedge mcu_clx2) begin
        if (mcu_rst) begin
            rmcr     <= '0;
            ctrl     <= '0;
            orfe     <= 1'b0;
            clr_arm  <= 1'b0;
            rdr_hold <= '0;
            tdr_last <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_rmcr) rmcr <= mcu_do;
            if (wr_trcsr) ctrl <= mcu_do[4:1];
            if (wr_tdr) tdr_last <= mcu_do;
            if (rd_rdr && rdrf) rdr_hold <= rx_head;
            if (rd_trcsr) clr_arm <= 1'b1;
            else if (rd_rdr) clr_arm <= 1'b0;
            if (orfe_set) orfe <= 1'b1;
            else if (rd_rdr && clr_arm) orfe <= 1'b0;
            irq <= (rie && (rdrf || orfe)) || (tie && tdre);
        end
    end

    always_comb begin
        iod = '0;
        unique case (1'b1)
            sel_rmcr:  iod = rmcr;
            sel_trcsr: iod = {rdrf, orfe, tdre, ctrl, 1'b0};
            sel_rdr:   iod = rdrf ? rx_head : rdr_hold;
            sel_tdr:   iod = tdr_last;
            default:   iod = '0;
        endcase
    end
endmodule
